// File: rtl/cost_pkg.sv
// cost_pkg: FSM encoding, index width and MSB-first element slice helpers for cost_sequencer.
package cost_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic int elem_msb(input int i, input int n, input int w);
    return (n - i) * w - 1;
  endfunction
endpackage

// File: rtl/sq_err_mac.sv
// sq_err_mac: combinational difference-square feeding a registered accumulator with clear/enable.
// COST_SATURATE_EN: full-width signed difference, wide accumulator, clamped cost plus sat flag.
module sq_err_mac import cost_pkg::*; #(
  parameter int data_size = 4,
  parameter int size = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 en,
  input  logic [data_size-1:0] y,
  input  logic [data_size-1:0] label,
  output logic [data_size-1:0] cost
`ifdef COST_SATURATE_EN
  ,
  output logic                 sat
`endif
);
`ifdef COST_SATURATE_EN
  localparam int sw = 2 * (data_size + 1);
  localparam int aw = sw + $clog2(size + 1);
  localparam logic [aw-1:0] cmax = aw'((1 << data_size) - 1);
  logic signed [data_size:0] d;
  logic [data_size:0] ad;
  logic [sw-1:0] sq;
  logic [aw-1:0] acc_q, acc_d;
  always_comb begin
    d = $signed({1'b0, label}) - $signed({1'b0, y});
    ad = d[data_size] ? $unsigned(-d) : $unsigned(d);
    sq = sw'(ad) * sw'(ad);
    acc_d = clr ? '0 : en ? acc_q + aw'(sq) : acc_q;
    sat = acc_q > cmax;
    cost = sat ? cmax[data_size-1:0] : acc_q[data_size-1:0];
  end
`else
  logic [data_size-1:0] d, sq, acc_q, acc_d;
  always_comb begin
    d = label - y;
    sq = d * d;
    acc_d = clr ? '0 : en ? acc_q + sq : acc_q;
  end
  assign cost = acc_q;
`endif
  always_ff @(posedge clk) acc_q <= !rst_n ? '0 : acc_d;
endmodule

// File: rtl/cost_sequencer.sv
// cost_sequencer: serial squared-error cost, one element per cycle through a shared MAC.
// Define COST_SATURATE_EN for a clamped cost and the sat output.
module cost_sequencer import cost_pkg::*; #(
  parameter int data_size = 4,
  parameter int size = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [data_size*size-1:0] y_stream,
  input  logic [data_size*size-1:0] label_stream,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [data_size-1:0]      cost,
  output logic                      busy
`ifdef COST_SATURATE_EN
  ,
  output logic                      sat
`endif
);
  localparam int iw = idx_w(size);
  localparam int msb = elem_msb(0, size, data_size);
  localparam logic [iw-1:0] last = iw'(size - 1);
  state_t state_q;
  logic [iw-1:0] idx_q;
  logic [data_size*size-1:0] y_q, l_q;
  logic in_ready_q, out_valid_q, busy_q, accept;
  assign accept = in_valid & in_ready_q;
  assign in_ready = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy = busy_q;
  // Vectors shift left each ACCUM cycle so the element being processed always sits in the MSB slice.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q <= '0;
      y_q <= '0;
      l_q <= '0;
      in_ready_q <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          y_q <= y_stream;
          l_q <= label_stream;
          idx_q <= '0;
          state_q <= ACCUM;
          in_ready_q <= 1'b0;
          busy_q <= 1'b1;
        end
        ACCUM: begin
          y_q <= y_q << data_size;
          l_q <= l_q << data_size;
          idx_q <= idx_q + 1'b1;
          if (idx_q == last) begin
            state_q <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        default: if (out_ready) begin
          state_q <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q <= 1'b1;
          busy_q <= 1'b0;
        end
      endcase
    end
  end
  sq_err_mac #(.data_size(data_size), .size(size)) u_mac (
    .clk(clk),
    .rst_n(rst_n),
    .clr(accept),
    .en(state_q == ACCUM),
    .y(y_q[msb -: data_size]),
    .label(l_q[msb -: data_size]),
    .cost(cost)
`ifdef COST_SATURATE_EN
    ,
    .sat(sat)
`endif
  );
endmodule

// File: tb/tb_cost_sequencer.sv
// tb_cost_sequencer: directed plus randomized transactions against an arithmetic cost model.
module tb_cost_sequencer;
  localparam int DS = 4;
  localparam int SZ = 3;
  localparam int W = DS * SZ;
  logic clk = 0;
  logic rst_n, in_valid, in_ready, out_valid, out_ready, busy;
  logic [W-1:0] y_stream, label_stream;
  logic [DS-1:0] cost;
`ifdef COST_SATURATE_EN
  logic sat;
`endif
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  cost_sequencer #(.data_size(DS), .size(SZ)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .y_stream(y_stream),
    .label_stream(label_stream),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .cost(cost),
    .busy(busy)
`ifdef COST_SATURATE_EN
    ,
    .sat(sat)
`endif
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic int sum_sq(input logic [W-1:0] yv, input logic [W-1:0] lv);
    int s = 0;
    for (int i = 0; i < SZ; i++) begin
      int yi = (int'(yv) >> (DS * (SZ - 1 - i))) % (1 << DS);
      int li = (int'(lv) >> (DS * (SZ - 1 - i))) % (1 << DS);
      s += (li - yi) * (li - yi);
    end
    return s;
  endfunction
  function automatic int exp_cost(input logic [W-1:0] yv, input logic [W-1:0] lv);
    int s = sum_sq(yv, lv);
`ifdef COST_SATURATE_EN
    return s > (1 << DS) - 1 ? (1 << DS) - 1 : s;
`else
    return s % (1 << DS);
`endif
  endfunction
  // Called at a negedge; returns at the negedge after the output handoff.
  task automatic send(input logic [W-1:0] yv, input logic [W-1:0] lv, input int stall, input bit keep, output int acc_at);
    int n;
    int e;
    e = exp_cost(yv, lv);
    in_valid = 1;
    y_stream = yv;
    label_stream = lv;
    out_ready = (stall == 0);
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_before_accept", in_ready, 1);
    acc_at = cyc;
    @(negedge clk);
    chk("busy_after_accept", busy, 1);
    chk("in_ready_after_accept", in_ready, 0);
    y_stream = W'($urandom);
    label_stream = W'($urandom);
    n = 1;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("latency", n, SZ + 1);
    chk("cost", cost, e);
`ifdef COST_SATURATE_EN
    chk("sat", sat, sum_sq(yv, lv) > (1 << DS) - 1);
`endif
    repeat (stall) begin
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_cost", cost, e);
      chk("hold_in_ready", in_ready, 0);
    end
    out_ready = 1;
    @(negedge clk);
    chk("valid_dropped", out_valid, 0);
    chk("idle_in_ready", in_ready, 1);
    chk("idle_busy", busy, 0);
    if (!keep) in_valid = 0;
  endtask
  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    int a, b, st, pst;
    bit k, pk;
    rst_n = 0;
    in_valid = 1;
    out_ready = 0;
    y_stream = '0;
    label_stream = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_cost", cost, 0);
    chk("rst_busy", busy, 0);
    in_valid = 0;
    rst_n = 1;
    @(negedge clk);
    send(12'h123, 12'h320, 0, 0, a);
    send(12'h000, 12'h330, 0, 0, a);
    send(12'h150, 12'h010, 0, 0, a);
    send(12'h123, 12'h320, 5, 0, a);
    in_valid = 1;
    y_stream = 12'h123;
    label_stream = 12'h320;
    out_ready = 1;
    @(negedge clk);
    in_valid = 0;
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_cost", cost, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_busy", busy, 0);
    repeat (SZ + 1) begin
      @(negedge clk);
      chk("midrst_no_present", out_valid, 0);
    end
    send(12'h123, 12'h320, 0, 0, a);
    send(12'h456, 12'hA1F, 0, 1, a);
    send(12'hFFF, 12'h000, 0, 0, b);
    chk("b2b_interval", b - a, SZ + 2);
    pk = 0;
    pst = 0;
    b = 0;
    for (int i = 0; i < 14; i++) begin
      st = $urandom_range(0, 3);
      k = (i < 13) && ($urandom_range(0, 1) == 1);
      send(W'($urandom), W'($urandom), st, k, a);
      if (pk) chk("rand_interval", a - b, SZ + 2 + pst);
      b = a;
      pk = k;
      pst = st;
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
